ofdm_rx_sync_ctrl: RTL and testbench

- Receive-side sequencer for the OFDM sync chain.
- Consumes the find strobes from the two ofdm_find_preamble instances (A, B) and the out_valid of ofdm_freq_sync.
- Drives reset and enable into ofdm_freq_sync and the correcting dds.
- After CFO lock, removes the cyclic prefix and frames each data symbol for the FFT.
- Sits between the preamble correlators/freq sync and the FFT input buffer.

---
 rtl/ofdm_rx_sync_pkg.sv | 29 ++
 rtl/ofdm_sync_timer.sv | 48 ++++
 rtl/ofdm_rx_sync_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ofdm_rx_sync_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_sync_pkg.sv
// ofdm_rx_sync_pkg: state codes, default symbol geometry shared with
// ofdm_frame_gen, and the counter-width helper for the RX sync controller.
package ofdm_rx_sync_pkg;

  // Default symbol geometry (kept in step with ofdm_frame_gen)
  localparam int FFT_LEN_DEF = 256;
  localparam int CP_LEN_DEF  = 64;

  typedef logic [2:0] state_t;

  localparam state_t ST_SEARCH_A = 3'd0;
  localparam state_t ST_WAIT_B   = 3'd1;
  localparam state_t ST_EST      = 3'd2;
  localparam state_t ST_SKIP_CP  = 3'd3;
  localparam state_t ST_SYMBOL   = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  // Width of one shared tick counter able to hold every terminal count.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m_ab;
    int m_cd;
    int m;
    m_ab = (a > b) ? a : b;
    m_cd = (c > d) ? c : d;
    m    = (m_ab > m_cd) ? m_ab : m_cd;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ofdm_sync_timer.sv
// ofdm_sync_timer: loadable tick counter with synchronous clear, count
// enable and terminal-count compare. Clear beats load beats increment.
module ofdm_sync_timer
  import ofdm_rx_sync_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_count_next,
  output logic         o_tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, load, increment or hold
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = W'(0);
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_inc) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= W'(0);
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count_next = count_d;
  assign o_tc         = (count_q == i_tc_val);

endmodule

// File: rtl/ofdm_rx_sync_ctrl.sv
// ofdm_rx_sync_ctrl: RX sync sequencer. Waits for preamble A then B, runs
// the CFO estimator until it locks, then strips the cyclic prefix and frames
// each data symbol for the FFT. All outputs are registered.
// Optional build macro: OFDM_RX_SYNC_STATS_EN adds frame statistics counters.
module ofdm_rx_sync_ctrl
  import ofdm_rx_sync_pkg::*;
#(
  parameter int FFT_LEN     = FFT_LEN_DEF,
  parameter int CP_LEN      = CP_LEN_DEF,
  parameter int B_WINDOW    = 512,
  parameter int EST_TIMEOUT = 128,
  parameter int SYM_W       = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic                       i_findPreamble_a,
  input  logic                       i_findPreamble_b,
  input  logic                       i_sync_valid,
  input  logic [SYM_W-1:0]           i_num_symbols,
  input  logic                       i_abort,
  output logic                       o_sync_reset,
  output logic                       o_sync_en,
  output logic                       o_frame_active,
  output logic                       o_sym_start,
  output logic                       o_sym_valid,
  output logic [SYM_W-1:0]           o_sym_index,
  output logic [$clog2(FFT_LEN)-1:0] o_sample_index,
  output logic                       o_frame_done,
  output logic                       o_timeout,
  output logic [2:0]                 o_state
`ifdef OFDM_RX_SYNC_STATS_EN
  ,
  output logic [15:0]                o_frames_ok,
  output logic [15:0]                o_frames_timeout,
  output logic [15:0]                o_frames_lost
`endif
);

  localparam int CNT_W  = cnt_width(B_WINDOW, EST_TIMEOUT, CP_LEN, FFT_LEN);
  localparam int SIDX_W = $clog2(FFT_LEN);

  state_t             state_q;
  state_t             state_d;
  logic [SYM_W-1:0]   num_q;
  logic [SYM_W-1:0]   num_d;
  logic [SYM_W-1:0]   sym_idx_q;
  logic [SYM_W-1:0]   sym_idx_d;
  logic [SYM_W-1:0]   sym_idx_nx_s;

  logic               tick_s;
  logic               tmr_clr_s;
  logic               tmr_inc_s;
  logic               tmr_tc_s;
  logic [CNT_W-1:0]   tmr_tc_val_s;
  logic [CNT_W-1:0]   tmr_cnt_next_s;

  logic               ev_timeout_s;
  logic               ev_lost_s;
  logic               ev_start_s;
  logic               ev_done_s;

  logic               sync_reset_d,   sync_reset_q;
  logic               sync_en_d,      sync_en_q;
  logic               frame_active_d, frame_active_q;
  logic               sym_start_d,    sym_start_q;
  logic               sym_valid_d,    sym_valid_q;
  logic [SIDX_W-1:0]  sample_idx_d,   sample_idx_q;
  logic               frame_done_d,   frame_done_q;
  logic               timeout_d,      timeout_q;

  assign tick_s = i_en & i_valid;

  // One timer serves the window, lock and sample counts: only one is live per state
  ofdm_sync_timer #(
    .W (CNT_W)
  ) u_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clr        (tmr_clr_s),
    .i_load       (1'b0),
    .i_load_val   (CNT_W'(0)),
    .i_inc        (tmr_inc_s),
    .i_tc_val     (tmr_tc_val_s),
    .o_count_next (tmr_cnt_next_s),
    .o_tc         (tmr_tc_s)
  );

  // Terminal count for the state currently being timed
  always_comb begin
    case (state_q)
      ST_WAIT_B:  tmr_tc_val_s = CNT_W'(B_WINDOW - 1);
      ST_EST:     tmr_tc_val_s = CNT_W'(EST_TIMEOUT - 1);
      ST_SKIP_CP: tmr_tc_val_s = CNT_W'(CP_LEN - 1);
      ST_SYMBOL:  tmr_tc_val_s = CNT_W'(FFT_LEN - 1);
      default:    tmr_tc_val_s = {CNT_W{1'b1}};
    endcase
  end

  // State and frame-context registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_SEARCH_A;
      num_q     <= SYM_W'(0);
      sym_idx_q <= SYM_W'(0);
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      sym_idx_q <= sym_idx_d;
    end
  end

  // Next state, timer control and event strobes; abort wins, i_en low freezes
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    sym_idx_nx_s = sym_idx_q;
    tmr_clr_s    = 1'b0;
    tmr_inc_s    = 1'b0;
    ev_timeout_s = 1'b0;
    ev_lost_s    = 1'b0;
    ev_start_s   = 1'b0;
    ev_done_s    = 1'b0;
    if (i_abort) begin
      state_d   = ST_SEARCH_A;
      tmr_clr_s = 1'b1;
    end else if (!i_en) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_SEARCH_A: begin
          if (tick_s && i_findPreamble_a) begin
            state_d   = ST_WAIT_B;
            tmr_clr_s = 1'b1;
          end else begin
            state_d = ST_SEARCH_A;
          end
        end
        ST_WAIT_B: begin
          if (!tick_s) begin
            state_d = ST_WAIT_B;
          end else if (i_findPreamble_b) begin
            num_d        = i_num_symbols;
            sym_idx_nx_s = SYM_W'(0);
            tmr_clr_s    = 1'b1;
            if (i_num_symbols == SYM_W'(0)) begin
              state_d   = ST_DONE;
              ev_done_s = 1'b1;
            end else begin
              state_d = ST_EST;
            end
          end else if (i_findPreamble_a) begin
            tmr_clr_s = 1'b1;
          end else if (tmr_tc_s) begin
            state_d      = ST_SEARCH_A;
            tmr_clr_s    = 1'b1;
            ev_timeout_s = 1'b1;
          end else begin
            tmr_inc_s = 1'b1;
          end
        end
        ST_EST: begin
          if (!tick_s) begin
            state_d = ST_EST;
          end else if (i_sync_valid) begin
            state_d   = ST_SKIP_CP;
            tmr_clr_s = 1'b1;
          end else if (tmr_tc_s) begin
            state_d      = ST_SEARCH_A;
            tmr_clr_s    = 1'b1;
            ev_timeout_s = 1'b1;
          end else begin
            tmr_inc_s = 1'b1;
          end
        end
        ST_SKIP_CP: begin
          if (!tick_s) begin
            state_d = ST_SKIP_CP;
          end else if (!i_sync_valid) begin
            state_d   = ST_SEARCH_A;
            tmr_clr_s = 1'b1;
            ev_lost_s = 1'b1;
          end else if (tmr_tc_s) begin
            state_d    = ST_SYMBOL;
            tmr_clr_s  = 1'b1;
            ev_start_s = 1'b1;
          end else begin
            tmr_inc_s = 1'b1;
          end
        end
        ST_SYMBOL: begin
          if (!tick_s) begin
            state_d = ST_SYMBOL;
          end else if (!i_sync_valid) begin
            state_d   = ST_SEARCH_A;
            tmr_clr_s = 1'b1;
            ev_lost_s = 1'b1;
          end else if (tmr_tc_s) begin
            tmr_clr_s = 1'b1;
            if (sym_idx_q == (num_q - SYM_W'(1))) begin
              state_d   = ST_DONE;
              ev_done_s = 1'b1;
            end else begin
              state_d      = ST_SKIP_CP;
              sym_idx_nx_s = sym_idx_q + SYM_W'(1);
            end
          end else begin
            tmr_inc_s = 1'b1;
          end
        end
        ST_DONE: begin
          state_d   = ST_SEARCH_A;
          tmr_clr_s = 1'b1;
        end
        default: begin
          state_d   = ST_SEARCH_A;
          tmr_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Symbol number restarts whenever the controller falls back to search
  assign sym_idx_d = (state_d == ST_SEARCH_A) ? SYM_W'(0) : sym_idx_nx_s;

  // Output values derived from the post-tick state and this cycle's events
  always_comb begin
    frame_active_d = (state_d == ST_EST) || (state_d == ST_SKIP_CP) || (state_d == ST_SYMBOL);
    sync_en_d      = frame_active_d;
    sync_reset_d   = ~frame_active_d;
    sym_valid_d    = (state_d == ST_SYMBOL);
    sample_idx_d   = sym_valid_d ? SIDX_W'(tmr_cnt_next_s) : SIDX_W'(0);
    sym_start_d    = ev_start_s;
    frame_done_d   = ev_done_s;
    timeout_d      = ev_timeout_s | ev_lost_s;
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_reset_q   <= 1'b1;
      sync_en_q      <= 1'b0;
      frame_active_q <= 1'b0;
      sym_start_q    <= 1'b0;
      sym_valid_q    <= 1'b0;
      sample_idx_q   <= SIDX_W'(0);
      frame_done_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sync_reset_q   <= sync_reset_d;
      sync_en_q      <= sync_en_d;
      frame_active_q <= frame_active_d;
      sym_start_q    <= sym_start_d;
      sym_valid_q    <= sym_valid_d;
      sample_idx_q   <= sample_idx_d;
      frame_done_q   <= frame_done_d;
      timeout_q      <= timeout_d;
    end
  end

  assign o_sync_reset   = sync_reset_q;
  assign o_sync_en      = sync_en_q;
  assign o_frame_active = frame_active_q;
  assign o_sym_start    = sym_start_q;
  assign o_sym_valid    = sym_valid_q;
  assign o_sym_index    = sym_idx_q;
  assign o_sample_index = sample_idx_q;
  assign o_frame_done   = frame_done_q;
  assign o_timeout      = timeout_q;
  assign o_state        = state_q;

`ifdef OFDM_RX_SYNC_STATS_EN
  logic [15:0] frames_ok_q;
  logic [15:0] frames_timeout_q;
  logic [15:0] frames_lost_q;

  // Wrapping frame statistics; abort produces no event and is not counted
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      frames_ok_q      <= 16'd0;
      frames_timeout_q <= 16'd0;
      frames_lost_q    <= 16'd0;
    end else begin
      frames_ok_q      <= frames_ok_q      + {15'd0, ev_done_s};
      frames_timeout_q <= frames_timeout_q + {15'd0, ev_timeout_s};
      frames_lost_q    <= frames_lost_q    + {15'd0, ev_lost_s};
    end
  end

  assign o_frames_ok      = frames_ok_q;
  assign o_frames_timeout = frames_timeout_q;
  assign o_frames_lost    = frames_lost_q;
`endif

endmodule

// File: tb/tb_ofdm_rx_sync_ctrl.sv
// tb_ofdm_rx_sync_ctrl: directed + randomized bench for ofdm_rx_sync_ctrl.
// Expected behaviour is computed from tick counts since each frame event.
module tb_ofdm_rx_sync_ctrl;

  localparam int FFT = 256;
  localparam int CP  = 64;
  localparam int BW  = 512;
  localparam int ET  = 128;
  localparam int PER = FFT + CP;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       valid;
  logic       fa;
  logic       fb;
  logic       sv;
  logic       abort_s;
  logic [7:0] nsym_in;

  logic       o_sync_reset;
  logic       o_sync_en;
  logic       o_frame_active;
  logic       o_sym_start;
  logic       o_sym_valid;
  logic [7:0] o_sym_index;
  logic [7:0] o_sample_index;
  logic       o_frame_done;
  logic       o_timeout;
  logic [2:0] o_state;
`ifdef OFDM_RX_SYNC_STATS_EN
  logic [15:0] o_frames_ok;
  logic [15:0] o_frames_timeout;
  logic [15:0] o_frames_lost;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ofdm_rx_sync_ctrl dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_en             (en),
    .i_valid          (valid),
    .i_findPreamble_a (fa),
    .i_findPreamble_b (fb),
    .i_sync_valid     (sv),
    .i_num_symbols    (nsym_in),
    .i_abort          (abort_s),
    .o_sync_reset     (o_sync_reset),
    .o_sync_en        (o_sync_en),
    .o_frame_active   (o_frame_active),
    .o_sym_start      (o_sym_start),
    .o_sym_valid      (o_sym_valid),
    .o_sym_index      (o_sym_index),
    .o_sample_index   (o_sample_index),
    .o_frame_done     (o_frame_done),
    .o_timeout        (o_timeout),
    .o_state          (o_state)
`ifdef OFDM_RX_SYNC_STATS_EN
    ,
    .o_frames_ok      (o_frames_ok),
    .o_frames_timeout (o_frames_timeout),
    .o_frames_lost    (o_frames_lost)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one clock of inputs, then sample 1 ns after the edge
  task automatic cyc(input int v, input int a, input int b, input int s);
    valid = (v != 0);
    fa    = (a != 0);
    fb    = (b != 0);
    sv    = (s != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"},   32'(o_state),        0);
    chk({tag, "_sreset"},  32'(o_sync_reset),   1);
    chk({tag, "_sen"},     32'(o_sync_en),      0);
    chk({tag, "_active"},  32'(o_frame_active), 0);
    chk({tag, "_svalid"},  32'(o_sym_valid),    0);
    chk({tag, "_sstart"},  32'(o_sym_start),    0);
    chk({tag, "_sample"},  32'(o_sample_index), 0);
    chk({tag, "_symidx"},  32'(o_sym_index),    0);
    chk({tag, "_done"},    32'(o_frame_done),   0);
    chk({tag, "_timeout"}, 32'(o_timeout),      0);
  endtask

  // Full frame: A at tick 10, B at tick 300, lock 20 ticks later, then symbols.
  // vmode 0: valid always, 1: valid toggles every clock, 2: random valid.
  task automatic run_frame(input int nsym, input int vmode);
    int j, m, s, guard, v, tog, prev_sv, tick_samples, sv_cycles, starts;
    int e_state, e_samp, e_start, e_done;
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0);
    chk("fr_pre_a", 32'(o_state), 0);
    nsym_in = 8'(nsym);
    cyc(1, 1, 0, 0);
    chk("fr_wait_b", 32'(o_state), 1);
    for (int k = 11; k < 300; k++) cyc(1, 0, 0, 0);
    chk("fr_still_wait_b", 32'(o_state), 1);
    chk("fr_wait_b_sreset", 32'(o_sync_reset), 1);
    cyc(1, 0, 1, 0);
    nsym_in = 8'($urandom_range(0, 255));
    chk("fr_est", 32'(o_state), 2);
    chk("fr_est_sen", 32'(o_sync_en), 1);
    chk("fr_est_sreset", 32'(o_sync_reset), 0);
    chk("fr_est_active", 32'(o_frame_active), 1);
    for (int k = 0; k < 19; k++) cyc(1, 0, 0, 0);
    chk("fr_est_hold", 32'(o_state), 2);
    cyc(1, 0, 0, 1);
    chk("fr_skip_cp", 32'(o_state), 3);
    j = 0; guard = 0; tog = 1; tick_samples = 0; sv_cycles = 0; starts = 0;
    while (j < nsym * PER && guard < 20000) begin
      guard++;
      case (vmode)
        0:       v = 1;
        1:       begin tog = 1 - tog; v = tog; end
        default: v = ($urandom_range(0, 2) != 0) ? 1 : 0;
      endcase
      prev_sv = int'(o_sym_valid);
      cyc(v, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1);
      if (v != 0) j++;
      if (prev_sv != 0 && v != 0) tick_samples++;
      sv_cycles += int'(o_sym_valid);
      starts    += int'(o_sym_start);
      m = j % PER;
      s = j / PER;
      e_samp = 0; e_start = 0; e_done = 0;
      if (m == 0 && s == nsym) begin
        e_state = 5; e_done = 1;
      end else if (m >= CP) begin
        e_state = 4; e_samp = m - CP; e_start = (v != 0 && m == CP) ? 1 : 0;
      end else begin
        e_state = 3;
      end
      chk("fr_state",   32'(o_state),        32'(e_state));
      chk("fr_svalid",  32'(o_sym_valid),    (e_state == 4) ? 1 : 0);
      chk("fr_sample",  32'(o_sample_index), 32'(e_samp));
      chk("fr_sstart",  32'(o_sym_start),    32'(e_start));
      chk("fr_done",    32'(o_frame_done),   32'(e_done));
      chk("fr_timeout", 32'(o_timeout),      0);
      if (e_state != 5) chk("fr_symidx", 32'(o_sym_index), 32'(s));
    end
    chk("fr_budget", 32'(j), 32'(nsym * PER));
    chk("fr_tick_samples", 32'(tick_samples), 32'(nsym * FFT));
    chk("fr_starts", 32'(starts), 32'(nsym));
    if (vmode == 0) chk("fr_sv_cycles", 32'(sv_cycles), 32'(nsym * FFT));
    if (vmode == 1) chk("fr_sv_cycles_half", 32'(sv_cycles), 32'(nsym * 2 * FFT));
    cyc(int'($urandom_range(0, 1)), 0, 0, 1);
    chk("fr_after_done", 32'(o_state), 0);
    chk("fr_after_done_pulse", 32'(o_frame_done), 0);
    chk("fr_after_done_sreset", 32'(o_sync_reset), 1);
    chk("fr_after_done_active", 32'(o_frame_active), 0);
  endtask

  // A with no B: timeout exactly BW ticks after the last A; restart_at>0 re-arms
  task automatic wait_b_timeout(input int restart_at);
    int k, v, guard;
    cyc(1, 1, 0, 0);
    chk("wb_enter", 32'(o_state), 1);
    if (restart_at > 0) begin
      for (int i = 1; i < restart_at; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("wb_restart", 32'(o_state), 1);
    end
    k = 0; guard = 0;
    while (k < BW && guard < 5000) begin
      guard++;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cyc(v, 0, 0, int'($urandom_range(0, 1)));
      if (v != 0) k++;
      chk("wb_timeout", 32'(o_timeout), (k == BW) ? 1 : 0);
      chk("wb_state", 32'(o_state), (k == BW) ? 0 : 1);
      chk("wb_sreset", 32'(o_sync_reset), 1);
    end
    chk("wb_budget", 32'(k), 32'(BW));
    cyc(1, 0, 0, 0);
    chk("wb_pulse_end", 32'(o_timeout), 0);
  endtask

  // Load the SYMBOL state at sample 0 of symbol 0 (two-symbol frame)
  task automatic goto_symbol();
    cyc(1, 1, 0, 0);
    nsym_in = 8'd2;
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < CP; k++) cyc(1, 0, 0, 1);
    chk("gs_state", 32'(o_state), 4);
    chk("gs_start", 32'(o_sym_start), 1);
    chk("gs_sample", 32'(o_sample_index), 0);
  endtask

  initial begin
    int k, v, en_ticks, guard;
    rst = 1'b1; en = 1'b1; valid = 1'b0; fa = 1'b0; fb = 1'b0; sv = 1'b0;
    abort_s = 1'b0; nsym_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;

    // Nominal two-symbol frame, then the same with 50% valid
    run_frame(2, 0);
    run_frame(2, 1);

    // Window timeout, plain and re-armed by a second A
    wait_b_timeout(0);
    wait_b_timeout(300);

    // A and B together: B wins; zero symbols goes straight to DONE
    cyc(1, 1, 0, 0);
    nsym_in = 8'd0;
    cyc(1, 1, 1, 0);
    chk("ab_zero_state", 32'(o_state), 5);
    chk("ab_zero_done", 32'(o_frame_done), 1);
    chk("ab_zero_active", 32'(o_frame_active), 0);
    chk("ab_zero_sreset", 32'(o_sync_reset), 1);
    cyc(0, 0, 0, 0);
    chk("ab_zero_next", 32'(o_state), 0);
    chk("ab_zero_pulse_end", 32'(o_frame_done), 0);
    cyc(1, 1, 0, 0);
    nsym_in = 8'd1;
    cyc(1, 1, 1, 0);
    chk("ab_b_wins", 32'(o_state), 2);
    abort_s = 1'b1;
    cyc(1, 0, 0, 0);
    abort_s = 1'b0;
    chk_idle("abort_est");

    // Lock never arrives: o_sync_en high for exactly ET ticks; strobes ignored
    cyc(1, 1, 0, 0);
    nsym_in = 8'd3;
    cyc(1, 0, 1, 0);
    k = 0; en_ticks = 0; guard = 0;
    while (k < ET && guard < 2000) begin
      guard++;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if (o_sync_en && v != 0) en_ticks++;
      cyc(v, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
      if (v != 0) k++;
      chk("est_sen", 32'(o_sync_en), (k < ET) ? 1 : 0);
      chk("est_timeout", 32'(o_timeout), (k == ET) ? 1 : 0);
      chk("est_state", 32'(o_state), (k < ET) ? 2 : 0);
    end
    chk("est_en_ticks", 32'(en_ticks), 32'(ET));

    // Randomized frames
    for (int r = 0; r < 3; r++) run_frame(int'($urandom_range(1, 3)), 2);

    // Lock loss at sample 100 of symbol 0
    goto_symbol();
    for (int i = 0; i < 100; i++) cyc(1, 0, 0, 1);
    chk("loss_pre_sample", 32'(o_sample_index), 100);
    cyc(1, 0, 0, 0);
    chk("loss_timeout", 32'(o_timeout), 1);
    chk("loss_svalid", 32'(o_sym_valid), 0);
    chk("loss_state", 32'(o_state), 0);
    cyc(1, 0, 0, 0);
    chk("loss_pulse_end", 32'(o_timeout), 0);

    // i_en low freezes everything and clears pulses; then abort in SYMBOL
    goto_symbol();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0);
      chk("frz_state", 32'(o_state), 4);
      chk("frz_sample", 32'(o_sample_index), 0);
      chk("frz_start", 32'(o_sym_start), 0);
      chk("frz_timeout", 32'(o_timeout), 0);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);
    chk("frz_resume_sample", 32'(o_sample_index), 5);
    abort_s = 1'b1;
    cyc(1, 0, 0, 0);
    abort_s = 1'b0;
    chk_idle("abort_sym");

    // Asynchronous reset in the middle of SKIP_CP
    cyc(1, 1, 0, 0);
    nsym_in = 8'd2;
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
    chk("rst_pre_state", 32'(o_state), 3);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 0, 0, 1);
    chk_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
